// File: rtl/seg7_display_arbiter_if.sv
// Overlay-source handshake bundle for the 7-segment scan arbiter.
// master = overlay source (drives ovl_req, ovl_chars).
// slave  = arbiter (drives ovl_gnt, ovl_done).
interface seg7_display_arbiter_if #(
    parameter int NUM_DIGITS = 6
);
    logic [7*NUM_DIGITS-1:0] ovl_chars;
    logic                    ovl_req;
    logic                    ovl_gnt;
    logic                    ovl_done;

    modport master (
        output ovl_req,
        output ovl_chars,
        input  ovl_gnt,
        input  ovl_done
    );

    modport slave (
        input  ovl_req,
        input  ovl_chars,
        output ovl_gnt,
        output ovl_done
    );
endinterface

// File: rtl/seg7_display_arbiter.sv
// Multiplexed 7-segment scan controller with CPU/overlay source arbiter.
// Ports: SEGclk, reset (sync, active-high), cpu_chars (7 bits/digit),
//   ovl (slave: ovl_req/ovl_chars in, ovl_gnt/ovl_done out),
//   digit_sel, seg_char, digit_en, frame_start.
// Optional SEG7_BRIGHTNESS_EN adds a 4-bit brightness input that trims
//   the lit part of each dwell; the value is latched per frame.
module seg7_display_arbiter #(
    parameter int         NUM_DIGITS = 6,
    parameter int         DWELL      = 1024,
    parameter int         BLANK      = 64,
    parameter int         OVL_FRAMES = 256,
    parameter logic [6:0] BLANK_CHAR = 7'h7F
) (
    input  logic                    SEGclk,
    input  logic                    reset,
    input  logic [7*NUM_DIGITS-1:0] cpu_chars,
    seg7_display_arbiter_if.slave   ovl,
`ifdef SEG7_BRIGHTNESS_EN
    input  logic [3:0]              brightness,
`endif
    output logic [3:0]              digit_sel,
    output logic [6:0]              seg_char,
    output logic                    digit_en,
    output logic                    frame_start
);
    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int FW = (OVL_FRAMES > 1) ? $clog2(OVL_FRAMES) : 1;

    typedef enum logic { SC_DWELL, SC_BLNK } scan_e;
    typedef enum logic [1:0] {
        SRC_CPU, SRC_WAIT, SRC_OVL, SRC_RLS
    } src_e;

    scan_e          scan_q, scan_d;
    src_e           src_q, src_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     digit_q, digit_d;
    logic [FW-1:0]  fcnt_q, fcnt_d;
    // run_q keeps outputs quiet while reset is held and for the
    // release cycle, so scanning starts cleanly at digit 0.
    logic           run_q, run_d;
`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]     bright_q, bright_d;
`endif

    logic           boundary;
    logic           last_dig;
    logic [3:0]     next_digit;
    logic           in_dwell;
    logic           lit;
    logic           done;

    always_ff @(posedge SEGclk) begin
        if (reset) begin
            scan_q   <= SC_DWELL;
            src_q    <= SRC_CPU;
            cnt_q    <= '0;
            digit_q  <= '0;
            fcnt_q   <= '0;
            run_q    <= 1'b0;
`ifdef SEG7_BRIGHTNESS_EN
            bright_q <= 4'hF;
`endif
        end else begin
            scan_q   <= scan_d;
            src_q    <= src_d;
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            fcnt_q   <= fcnt_d;
            run_q    <= run_d;
`ifdef SEG7_BRIGHTNESS_EN
            bright_q <= bright_d;
`endif
        end
    end

    // Scan sequencing: DWELL then optional BLNK per digit.
    always_comb begin
        scan_d     = scan_q;
        cnt_d      = cnt_q;
        digit_d    = digit_q;
        run_d      = 1'b1;
        boundary   = 1'b0;
        last_dig   = (digit_q == 4'(NUM_DIGITS - 1));
        next_digit = last_dig ? 4'd0 : digit_q + 4'd1;
        if (run_q) begin
            unique case (scan_q)
                SC_DWELL: begin
                    if (cnt_q == CW'(DWELL - 1)) begin
                        cnt_d = '0;
                        if (BLANK == 0) begin
                            digit_d  = next_digit;
                            boundary = last_dig;
                        end else begin
                            scan_d = SC_BLNK;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                SC_BLNK: begin
                    if (cnt_q == CW'(BLANK - 1)) begin
                        cnt_d    = '0;
                        scan_d   = SC_DWELL;
                        digit_d  = next_digit;
                        boundary = last_dig;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    // Source ownership only changes on a frame boundary.
    always_comb begin
        src_d  = src_q;
        fcnt_d = fcnt_q;
        done   = 1'b0;
        if (run_q) begin
            unique case (src_q)
                SRC_CPU: begin
                    if (ovl.ovl_req) src_d = SRC_WAIT;
                end
                SRC_WAIT: begin
                    if (!ovl.ovl_req) src_d = SRC_CPU;
                    else if (boundary) src_d = SRC_OVL;
                end
                SRC_OVL: begin
                    if (boundary) begin
                        if (fcnt_q == FW'(OVL_FRAMES - 1)) begin
                            done   = 1'b1;
                            fcnt_d = '0;
                            src_d  = SRC_RLS;
                        end else begin
                            fcnt_d = fcnt_q + FW'(1);
                        end
                    end
                end
                SRC_RLS: begin
                    if (boundary) src_d = SRC_CPU;
                end
            endcase
        end
    end

    always_comb begin
        logic [7*NUM_DIGITS-1:0] chars;
        int                      base;
        in_dwell    = run_q && (scan_q == SC_DWELL);
        frame_start = in_dwell && (cnt_q == '0) && (digit_q == '0);
`ifdef SEG7_BRIGHTNESS_EN
        begin
            logic [3:0] b_eff;
            int         lim;
            // The new value must already apply on the frame_start cycle.
            b_eff    = frame_start ? brightness : bright_q;
            bright_d = b_eff;
            lim      = ((int'(b_eff) + 1) * DWELL) >> 4;
            lit      = in_dwell && (int'(cnt_q) < lim);
        end
`else
        lit = in_dwell;
`endif
        chars     = (src_q == SRC_OVL) ? ovl.ovl_chars : cpu_chars;
        base      = 7 * int'(digit_q);
        digit_en  = lit;
        seg_char  = lit ? chars[base +: 7] : BLANK_CHAR;
        digit_sel = digit_q;
    end

    assign ovl.ovl_gnt  = (src_q == SRC_OVL);
    assign ovl.ovl_done = done;
endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Self-checking bench for seg7_display_arbiter.
// Reference model is frame/position arithmetic plus an ownership ledger.
module tb_seg7_display_arbiter;
    localparam int ND    = 6;
    localparam int DW    = 4;
    localparam int BL    = 1;
    localparam int OF    = 2;
    localparam int PER   = DW + BL;
    localparam int FRAME = ND * PER;

    logic            SEGclk = 1'b0;
    logic            reset  = 1'b1;
    logic [7*ND-1:0] cpu_chars;
    logic [3:0]      digit_sel;
    logic [6:0]      seg_char;
    logic            digit_en;
    logic            frame_start;
`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]      brightness = 4'hF;
`endif

    seg7_display_arbiter_if #(.NUM_DIGITS(ND)) ovl ();

    seg7_display_arbiter #(
        .NUM_DIGITS(ND), .DWELL(DW), .BLANK(BL),
        .OVL_FRAMES(OF), .BLANK_CHAR(7'h7F)
    ) dut (
        .SEGclk      (SEGclk),
        .reset       (reset),
        .cpu_chars   (cpu_chars),
        .ovl         (ovl),
`ifdef SEG7_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .digit_sel   (digit_sel),
        .seg_char    (seg_char),
        .digit_en    (digit_en),
        .frame_start (frame_start)
    );

    always #5 SEGclk = ~SEGclk;

    int checks = 0;
    int errors = 0;

    // Model: cycle index since release, and who owns the display.
    int m_t;
    bit m_pend;
    int m_left;
    bit m_rls;

    localparam logic [14:0] RST_VEC = {1'b0, 4'd0, 1'b0, 7'h7F, 1'b0, 1'b0};

    task automatic model_reset();
        m_t    = 0;
        m_pend = 0;
        m_left = 0;
        m_rls  = 0;
    endtask

    task automatic model_step(input logic req);
        bit bnd;
        bnd = (m_t % FRAME) == FRAME - 1;
        if (m_left > 0) begin
            if (bnd) begin
                m_left--;
                if (m_left == 0) m_rls = 1;
            end
        end else if (m_rls) begin
            if (bnd) m_rls = 0;
        end else if (m_pend) begin
            if (!req) m_pend = 0;
            else if (bnd) begin
                m_pend = 0;
                m_left = OF;
            end
        end else if (req) begin
            m_pend = 1;
        end
        m_t++;
    endtask

    function automatic logic [14:0] model_out();
        int         pos, d;
        logic       en, g;
        logic [6:0] c;
        pos = m_t % FRAME;
        d   = pos / PER;
        en  = (pos % PER) < DW;
        g   = m_left > 0;
        c   = g ? ovl.ovl_chars[7*d +: 7] : cpu_chars[7*d +: 7];
        return {pos == 0, 4'(d), en, en ? c : 7'h7F, g,
                (pos == FRAME - 1) && (m_left == 1)};
    endfunction

    function automatic logic [14:0] got_vec();
        return {frame_start, digit_sel, digit_en, seg_char,
                ovl.ovl_gnt, ovl.ovl_done};
    endfunction

    task automatic rand_chars();
        logic [6:0] b0, b1;
        b0 = 7'($urandom);
        b1 = 7'($urandom);
        for (int i = 0; i < ND; i++) begin
            cpu_chars[7*i +: 7]     = b0 + 7'(17 * i);
            ovl.ovl_chars[7*i +: 7] = b1 + 7'(23 * i);
        end
    endtask

    task automatic tick(input logic req, input bit rnd);
        @(negedge SEGclk);
        ovl.ovl_req = req;
        if (rnd) rand_chars();
        #1;
    endtask

    task automatic apply_reset();
        @(negedge SEGclk);
        reset       = 1'b1;
        ovl.ovl_req = 1'b0;
        @(negedge SEGclk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [14:0] got;
        rand_chars();
        @(negedge SEGclk);
        reset       = 1'b1;
        ovl.ovl_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge SEGclk);
            rand_chars();
            #1;
            got = got_vec();
            checks++;
            if (got !== RST_VEC) begin
                errors++;
                $display("FAIL reset_vals got %h exp %h", got, RST_VEC);
            end
        end
    endtask

    task automatic test_scan();
        logic [14:0] got, exp;
        int          fs_n = 0;
        rand_chars();
        apply_reset();
        for (int t = 0; t < 70; t++) begin
            tick(1'b0, 0);
            got = got_vec();
            exp = model_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL scan t=%0d got %h exp %h", t, got, exp);
            end
            if (frame_start) fs_n++;
            model_step(1'b0);
        end
        checks++;
        if (fs_n != 3) begin
            errors++;
            $display("FAIL scan_fs_count got %0d exp 3", fs_n);
        end
    endtask

    task automatic test_overlay();
        logic [14:0] got, exp;
        logic        req, pg = 1'b0;
        int          first_g = -1, done_at = -1, fall_at = -1, gcnt = 0;
        rand_chars();
        apply_reset();
        for (int t = 0; t < 130; t++) begin
            req = (t >= 10) && (t < 40);
            tick(req, 0);
            got = got_vec();
            exp = model_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL overlay t=%0d got %h exp %h", t, got, exp);
            end
            if (ovl.ovl_gnt) gcnt++;
            if (ovl.ovl_gnt && first_g < 0) first_g = t;
            if (ovl.ovl_done) done_at = t;
            if (!ovl.ovl_gnt && pg && fall_at < 0) fall_at = t;
            pg = ovl.ovl_gnt;
            model_step(req);
        end
        checks += 4;
        if (first_g != 30) begin
            errors++;
            $display("FAIL gnt_rise got %0d exp 30", first_g);
        end
        if (done_at != 89) begin
            errors++;
            $display("FAIL done_cycle got %0d exp 89", done_at);
        end
        if (fall_at != 90) begin
            errors++;
            $display("FAIL gnt_fall got %0d exp 90", fall_at);
        end
        if (gcnt != 60) begin
            errors++;
            $display("FAIL gnt_len got %0d exp 60", gcnt);
        end
    endtask

    task automatic test_hold();
        logic [14:0] got, exp;
        logic        fg = 1'b0, want;
        int          f;
        rand_chars();
        apply_reset();
        for (int t = 0; t < 8 * FRAME; t++) begin
            tick(1'b1, 0);
            got = got_vec();
            exp = model_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL hold t=%0d got %h exp %h", t, got, exp);
            end
            f = t / FRAME;
            if (t % FRAME == 0) fg = ovl.ovl_gnt;
            if (t % FRAME == FRAME - 1) begin
                checks++;
                if (ovl.ovl_gnt !== fg) begin
                    errors++;
                    $display("FAIL frame_mix f=%0d got %b exp %b",
                             f, ovl.ovl_gnt, fg);
                end
            end
            if (t % FRAME == 15) begin
                want = (f % 4 == 1) || (f % 4 == 2);
                checks++;
                if (ovl.ovl_gnt !== want) begin
                    errors++;
                    $display("FAIL hold_pattern f=%0d got %b exp %b",
                             f, ovl.ovl_gnt, want);
                end
            end
            model_step(1'b1);
        end
    endtask

    task automatic test_withdraw();
        logic [14:0] got, exp;
        logic        req;
        int          gcnt = 0, dcnt = 0;
        rand_chars();
        apply_reset();
        for (int t = 0; t < 100; t++) begin
            req = (t >= 5) && (t < 12);
            tick(req, 0);
            got = got_vec();
            exp = model_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL withdraw t=%0d got %h exp %h", t, got, exp);
            end
            if (ovl.ovl_gnt) gcnt++;
            if (ovl.ovl_done) dcnt++;
            model_step(req);
        end
        checks++;
        if (gcnt != 0 || dcnt != 0) begin
            errors++;
            $display("FAIL withdraw_gnt got gnt=%0d done=%0d exp 0/0",
                     gcnt, dcnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] got, exp;
        int          dcnt = 0;
        rand_chars();
        apply_reset();
        for (int t = 0; t <= 45; t++) begin
            tick(1'b1, 0);
            got = got_vec();
            exp = model_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rstmid t=%0d got %h exp %h", t, got, exp);
            end
            if (ovl.ovl_done) dcnt++;
            model_step(1'b1);
        end
        reset = 1'b1;
        tick(1'b1, 0);
        got = got_vec();
        checks++;
        if (got !== RST_VEC) begin
            errors++;
            $display("FAIL rstmid_vals got %h exp %h", got, RST_VEC);
        end
        reset = 1'b0;
        model_reset();
        for (int t = 0; t < 40; t++) begin
            tick(1'b1, 0);
            got = got_vec();
            exp = model_out();
            if (t == 0) begin
                checks++;
                if (frame_start !== 1'b1 || digit_sel !== 4'd0) begin
                    errors++;
                    $display("FAIL rstmid_restart got fs=%b sel=%0d exp 1/0",
                             frame_start, digit_sel);
                end
            end
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rstmid2 t=%0d got %h exp %h", t, got, exp);
            end
            if (ovl.ovl_done) dcnt++;
            model_step(1'b1);
        end
        checks++;
        if (dcnt != 0) begin
            errors++;
            $display("FAIL rstmid_done got %0d exp 0", dcnt);
        end
    endtask

    task automatic test_random();
        logic [14:0] got, exp;
        logic        req = 1'b0;
        apply_reset();
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 19) == 0) req = ~req;
            tick(req, 1);
            got = got_vec();
            exp = model_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random t=%0d got %h exp %h", t, got, exp);
            end
            model_step(req);
        end
    endtask

    initial begin
        ovl.ovl_req   = 1'b0;
        cpu_chars     = '0;
        ovl.ovl_chars = '0;
        test_reset();
        test_scan();
        test_overlay();
        test_hold();
        test_withdraw();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
